// File: rtl/mem_responder.sv
// Memory responder: word RAM behind a read/write request handshake that completes a fixed
// LATENCY clock edges after the request is sampled, with an illegal-request error pulse.
module mem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic [8:0]  addr,
  input  logic [31:0] dataIn,
  output logic [31:0] Mdatain,
  output logic        done,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            capture, access;
  logic [AW-1:0]   addr_q, addr_idx;
  logic [31:0]     data_q;
  logic            op_wr_q;
  logic [31:0]     mdata_q;
  logic [31:0]     mem [DEPTH];

  // Out-of-range addresses alias onto the physical array.
  assign addr_idx = AW'(32'(addr) % DEPTH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (read && write) begin
          err_d = 1'b1;
        end else if (read || write) begin
          capture = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'h0;
      op_wr_q <= 1'b0;
      mdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= addr_idx;
        data_q  <= dataIn;
        op_wr_q <= write;
      end
      if (access && !op_wr_q) begin
        mdata_q <= mem[addr_q];
      end
    end
  end

  // RAM is not reset; an abort returns the FSM to idle so the write never fires.
  always_ff @(posedge clk) begin
    if (access && op_wr_q) begin
      mem[addr_q] <= data_q;
    end
  end

  assign Mdatain = mdata_q;
  assign done    = (state_q == StDone);
  assign busy    = (state_q != StIdle);
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of transactions with a completion scoreboard, plus
// hand-written sequences for illegal requests, ignored activity, abort and held requests.
module tb_mem_responder;

  localparam int L0 = 2;

  logic        clk = 1'b0;
  logic        clr;
  logic        read, write;
  logic [8:0]  addr;
  logic [31:0] dataIn;
  logic [31:0] mdatain;
  logic        done, busy, err;

  logic        read1, write1;
  logic [8:0]  addr1;
  logic [31:0] dataIn1;
  logic [31:0] mdatain1;
  logic        done1, busy1, err1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[11];

  mem_responder #(.DEPTH(256), .LATENCY(L0)) u0 (
    .clk(clk), .clr(clr), .read(read), .write(write), .addr(addr), .dataIn(dataIn),
    .Mdatain(mdatain), .done(done), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH(512), .LATENCY(1)) u1 (
    .clk(clk), .clr(clr), .read(read1), .write(write1), .addr(addr1), .dataIn(dataIn1),
    .Mdatain(mdatain1), .done(done1), .busy(busy1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion on u0 must match the oldest expected Mdatain.
  always @(negedge clk) begin
    if (!clr && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=done required=no_done");
      end else begin
        check("mdatain_on_done", mdatain, exp_q.pop_front());
      end
    end
  end

  task automatic txn(input bit wr, input logic [8:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit noise);
    @(negedge clk);
    read   = !wr;
    write  = wr;
    addr   = a;
    dataIn = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    read   = 1'b0;
    write  = 1'b0;
    addr   = 9'($urandom);
    dataIn = $urandom;
    for (int i = 0; i <= L0; i++) begin
      @(negedge clk);
      check("busy_in_flight", 32'(busy), 32'd1);
      check("done_timing", 32'(done), 32'(i == L0));
      if (noise) begin
        write  = 1'b1;
        addr   = 9'h003;
        dataIn = 32'h1;
      end
    end
    @(negedge clk);
    read  = 1'b0;
    write = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 9'h005, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 9'h005, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 9'h00A, 32'h00001111, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 9'h10A, 32'h22223333, 32'hDEADBEEF};
    tbl[4]  = '{1'b0, 9'h00A, 32'h0,        32'h22223333};
    tbl[5]  = '{1'b1, 9'h100, 32'h12345678, 32'h22223333};
    tbl[6]  = '{1'b0, 9'h000, 32'h0,        32'h12345678};
    tbl[7]  = '{1'b1, 9'h007, 32'hAAAA5555, 32'h12345678};
    tbl[8]  = '{1'b1, 9'h003, 32'h33333333, 32'h12345678};
    tbl[9]  = '{1'b1, 9'h0FF, 32'h0BADF00D, 32'h12345678};
    tbl[10] = '{1'b0, 9'h1FF, 32'h0,        32'h0BADF00D};

    clr = 1'b1;
    read = 1'b0; write = 1'b0; addr = '0; dataIn = '0;
    read1 = 1'b0; write1 = 1'b0; addr1 = '0; dataIn1 = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mdatain", mdatain, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;

    for (int i = 0; i < 11; i++) begin
      txn(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].exp, 1'b0);
    end

    // Both request lines high: error pulse only.
    @(negedge clk);
    read = 1'b1; write = 1'b1; addr = 9'h005; dataIn = 32'hFFFFFFFF;
    @(posedge clk);
    #1 read = 1'b0; write = 1'b0;
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    check("err_mdatain", mdatain, 32'h0BADF00D);
    @(negedge clk);
    check("err_one_cycle", 32'(err), 32'd0);
    check("err_busy_after", 32'(busy), 32'd0);

    // Writes to addr 3 while a read of addr 3 is in flight must be dropped.
    txn(1'b0, 9'h003, 32'h0, 32'h33333333, 1'b1);
    txn(1'b0, 9'h003, 32'h0, 32'h33333333, 1'b0);

    // Abort a write mid-flight; RAM must keep its old word.
    @(negedge clk);
    write = 1'b1; addr = 9'h007; dataIn = 32'hCAFE0000;
    @(posedge clk);
    #1 write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #1 clr = 1'b1;
    #1;
    check("abort_mdatain", mdatain, 32'h0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;
    txn(1'b0, 9'h007, 32'h0, 32'hAAAA5555, 1'b0);

    // LATENCY=1 instance: seed addr 1, then hold read high.
    @(negedge clk);
    write1 = 1'b1; addr1 = 9'h001; dataIn1 = 32'h00000011;
    @(posedge clk);
    #1 write1 = 1'b0;
    @(negedge clk);
    check("l1_busy", 32'(busy1), 32'd1);
    check("l1_done_early", 32'(done1), 32'd0);
    @(negedge clk);
    check("l1_done", 32'(done1), 32'd1);
    @(negedge clk);
    check("l1_idle", 32'(busy1), 32'd0);
    read1 = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check("held_done_period", 32'(done1), 32'((c % 3) == 1));
      if (done1) check("held_mdatain", mdatain1, 32'h00000011);
    end
    read1 = 1'b0;
    repeat (4) @(negedge clk);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
